tlm_fifo_hw: RTL and testbench
==============================

// Module: tlm_fifo_hw
// PURPOSE
// - Synthesizable bounded FIFO channel between a producer and a consumer (e.g. stimulus source -> reference model).
// - Carries one transaction word per handshake, in strict order, with a fixed capacity (default 3).
// - Gives the hardware equivalent of a put_export / get_export pair: blocking is expressed as ready/valid backpressure.
// PARAMETERS
// - WIDTH  default 32  bits per transaction word (>=1)
// - DEPTH  default 3   capacity in words (>=1; need not be a power of two)
// PORTS
// - clk        in   1                   single clock; all state updates on rising edge
// - rst        in   1                   synchronous, active-high reset
// - put_valid  in   1                   producer offers put_data this cycle
// - put_ready  out  1                   FIFO can accept a word (= !full)
// - put_data   in   WIDTH               word to enqueue
// - get_valid  out  1                   head word available (= !empty)
// - get_ready  in   1                   consumer takes the head word this cycle
// - get_data   out  WIDTH               head word (oldest stored)
// - count      out  $clog2(DEPTH+1)     number of stored words
// - full       out  1                   count == DEPTH
// - empty      out  1                   count == 0
// BEHAVIOUR
// - Interface: one clock (clk); reset (rst) is synchronous and active-high.
// - put fires when put_valid && put_ready; get fires when get_valid && get_ready; both are evaluated at the rising edge.
// - Reset (sampled on a clk edge while rst=1):
//   - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0.
//   - put_ready=1, get_valid=0, get_data=0.
//   - Storage contents are don't-care.
//   - Reset wins over any put or get in the same cycle.
// - Outputs are combinational from registered state only: no input-to-output paths.
//   - put_ready = !full; get_valid = !empty.
//   - get_data = mem[rd_ptr] when !empty, else all zeros.
// - Latency: a word put at edge N is visible on get_data/get_valid after edge N. No same-cycle bypass: an empty FIFO never presents put_data.
// - Pointers: increment on fire, wrap from DEPTH-1 to 0. This also holds for non-power-of-two DEPTH.
// - count update:
//   - +1 on put only; -1 on get only.
//   - Unchanged on simultaneous put+get.
// - Full: put_ready=0, so put_valid is ignored and the data is not written.
//   - A get in the same cycle frees a slot. The producer may put on the next cycle; put_ready never depends on get_ready.
// - Empty: get_ready is ignored; count never underflows.
// - Simultaneous put+get with 0<count<DEPTH: both happen; the read returns the old head.
// - Ordering: strict FIFO; no word is lost, duplicated or reordered.
// - Holding: put_data may change while put_valid=0. get_data is stable while get_valid=1 and no get fires.
// - Assertions (simulation only): count<=DEPTH; full and empty never both 1 unless DEPTH==0 (illegal).
// CONFIGURATION
// - TLM_FIFO_FLUSH_EN defined:
//   - Adds input port `flush` (1 bit, synchronous, active-high).
//   - On an edge with flush=1 and rst=0: pointers and count go to 0, and any put/get that cycle is discarded.
//   - Outputs then match the reset state. Reset still has priority over flush.
// - TLM_FIFO_FLUSH_EN undefined: there is no `flush` port and no flush logic.
// TESTING
// - Reset: hold rst=1 for 2 cycles with put_valid=1 -> count=0, empty=1, full=0, put_ready=1, get_valid=0, get_data=0.
// - Fill/drain: put 0xA1, 0xA2, 0xA3 (DEPTH=3) -> full=1, put_ready=0. Put 0xA4 while full is dropped. Gets return A1, A2, A3, then empty=1.
// - Wrap-around: 10 interleaved puts/gets of 0..9 with count between 1 and 2 -> output order 0..9, with pointers passing the 2->0 wrap several times.
// - Simultaneous: count=2, put 0x55 and get in the same cycle -> old head returned, count stays 2, 0x55 ends up last.
// - Full+get: count=3 with get_ready=1 and put_valid=1 -> only the get fires (count=2). The put is accepted next cycle (count=3).
// - Flush (with TLM_FIFO_FLUSH_EN): count=2, assert flush with put_valid=1 -> count=0 and empty=1 on the next cycle, and the new word is not stored.

Source files
------------

// File: rtl/tlm_fifo_hw.sv
`default_nettype none
// ============================================================================
// Module   : tlm_fifo_hw
// Purpose  : Bounded, strictly ordered FIFO channel between a producer and a
//            consumer. It is the hardware form of a put/get export pair, with
//            blocking expressed as ready/valid backpressure. DEPTH need not be
//            a power of two.
// Ports    : clk, rst       - single clock, synchronous active-high reset
//            put_valid/put_ready/put_data - producer handshake (ready = !full)
//            get_valid/get_ready/get_data - consumer handshake (valid = !empty)
//            count, full, empty           - occupancy status
//            flush (only with TLM_FIFO_FLUSH_EN) - synchronous clear
// Options  : TLM_FIFO_FLUSH_EN - adds the flush port and its clear logic
// Revision : 1.0 - initial release
// ============================================================================
module tlm_fifo_hw #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3
) (
   input  logic                       clk,
   input  logic                       rst,
`ifdef TLM_FIFO_FLUSH_EN
   input  logic                       flush,
`endif
   input  logic                       put_valid,
   output logic                       put_ready,
   input  logic [WIDTH-1:0]           put_data,
   output logic                       get_valid,
   input  logic                       get_ready,
   output logic [WIDTH-1:0]           get_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int CW = $clog2(DEPTH + 1);
   // A one-entry FIFO still needs a one-bit pointer to index storage.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             put_fire;
   logic             get_fire;

   // Explicit wrap keeps the pointers inside 0..DEPTH-1 for any DEPTH.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // All outputs derive from registered state only.
   assign full      = (count == COUNT_MAX);
   assign empty     = (count == '0);
   assign put_ready = !full;
   assign get_valid = !empty;
   assign get_data  = empty ? '0 : mem[rd_ptr];

   assign put_fire  = put_valid && put_ready;
   assign get_fire  = get_ready && get_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end
`ifdef TLM_FIFO_FLUSH_EN
      else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end
`endif
      else begin
         if (put_fire) wr_ptr <= ptr_next(wr_ptr);
         if (get_fire) rd_ptr <= ptr_next(rd_ptr);
         case ({put_fire, get_fire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; the write is suppressed whenever the
   // pointers are being cleared so a discarded put leaves no trace.
   always_ff @(posedge clk) begin
`ifdef TLM_FIFO_FLUSH_EN
      if (put_fire && !rst && !flush) mem[wr_ptr] <= put_data;
`else
      if (put_fire && !rst) mem[wr_ptr] <= put_data;
`endif
   end

   a_count_bound : assert property (@(posedge clk) disable iff (rst)
      count <= COUNT_MAX);
   a_full_empty  : assert property (@(posedge clk) disable iff (rst)
      !(full && empty));

endmodule
`default_nettype wire

// File: tb/tb_tlm_fifo_hw.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlm_fifo_hw
// Purpose  : Self-checking bench for tlm_fifo_hw (WIDTH=32, DEPTH=3). A queue
//            holds the expected contents; every cycle the observable outputs
//            are compared against it. Directed scenarios are followed by
//            randomized traffic.
// Options  : TLM_FIFO_FLUSH_EN - also exercises the flush port
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlm_fifo_hw;

   localparam int WIDTH = 32;
   localparam int DEPTH = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             put_valid = 1'b0;
   logic             put_ready;
   logic [WIDTH-1:0] put_data = '0;
   logic             get_valid;
   logic             get_ready = 1'b0;
   logic [WIDTH-1:0] get_data;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
`ifdef TLM_FIFO_FLUSH_EN
   logic             flush = 1'b0;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [WIDTH-1:0] model_q [$];

   tlm_fifo_hw #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef TLM_FIFO_FLUSH_EN
      .flush     (flush),
`endif
      .put_valid (put_valid),
      .put_ready (put_ready),
      .put_data  (put_data),
      .get_valid (get_valid),
      .get_ready (get_ready),
      .get_data  (get_data),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
   endtask

   // Compare every observable output against the reference queue.
   task automatic check_all(input string tag);
      int sz;
      sz = model_q.size();
      check({tag, ".count"},     32'(count),     32'(sz));
      check({tag, ".full"},      32'(full),      32'(sz == DEPTH));
      check({tag, ".empty"},     32'(empty),     32'(sz == 0));
      check({tag, ".put_ready"}, 32'(put_ready), 32'(sz != DEPTH));
      check({tag, ".get_valid"}, 32'(get_valid), 32'(sz != 0));
      check({tag, ".get_data"},  32'(get_data),  (sz != 0) ? 32'(model_q[0]) : 32'h0);
   endtask

   // One clock cycle of traffic; the model follows the channel's rules
   // using occupancy as it was before the edge.
   task automatic step(input logic pv, input logic [WIDTH-1:0] pd, input logic gr,
                       input string tag);
      bit do_put, do_get;
      @(negedge clk);
      put_valid = pv;
      put_data  = pd;
      get_ready = gr;
      do_put = pv && (model_q.size() < DEPTH);
      do_get = gr && (model_q.size() > 0);
      @(posedge clk);
      if (do_get) void'(model_q.pop_front());
      if (do_put) model_q.push_back(pd);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst       = 1'b1;
      put_valid = 1'b1;
      put_data  = 32'hDEAD_BEEF;
      get_ready = 1'b1;
      repeat (cycles) @(posedge clk);
      model_q.delete();
      #1;
      check_all("reset");
      check("reset.get_data_zero", 32'(get_data), 32'h0);
      @(negedge clk);
      rst       = 1'b0;
      put_valid = 1'b0;
      get_ready = 1'b0;
   endtask

   initial begin
      do_reset(2);

      // Fill, drop the put while full, then drain in order.
      step(1, 32'hA1, 0, "fill1");
      step(1, 32'hA2, 0, "fill2");
      step(1, 32'hA3, 0, "fill3");
      check("fill.full", 32'(full), 32'h1);
      step(1, 32'hA4, 0, "drop_full");
      step(0, 32'h0, 1, "drain1");
      check("drain1.head", 32'(get_data), 32'hA2);
      step(0, 32'h0, 1, "drain2");
      step(0, 32'h0, 1, "drain3");
      check("drain.empty", 32'(empty), 32'h1);
      step(0, 32'h0, 1, "get_on_empty");

      // Interleaved traffic crossing the pointer wrap several times.
      step(1, 32'd0, 0, "wrap_prime");
      for (int i = 1; i < 10; i++) begin
         check("wrap.order", 32'(get_data), 32'(i - 1));
         step(1, 32'(i), 1, "wrap");
      end
      check("wrap.last", 32'(get_data), 32'd9);
      step(0, 32'h0, 1, "wrap_drain");

      // Simultaneous put+get at count 2.
      step(1, 32'h11, 0, "sim_a");
      step(1, 32'h22, 0, "sim_b");
      step(1, 32'h55, 1, "sim_both");
      check("sim.count", 32'(count), 32'd2);
      step(0, 32'h0, 1, "sim_d1");
      check("sim.tail", 32'(get_data), 32'h55);
      step(0, 32'h0, 1, "sim_d2");

      // Full with get and put both asserted: only the get fires.
      step(1, 32'hB1, 0, "fg1");
      step(1, 32'hB2, 0, "fg2");
      step(1, 32'hB3, 0, "fg3");
      step(1, 32'hB4, 1, "fg_both");
      check("fg.count_after_get", 32'(count), 32'd2);
      step(1, 32'hB4, 0, "fg_put");
      check("fg.count_after_put", 32'(count), 32'd3);
      repeat (3) step(0, 32'h0, 1, "fg_drain");

`ifdef TLM_FIFO_FLUSH_EN
      step(1, 32'hC1, 0, "fl1");
      step(1, 32'hC2, 0, "fl2");
      @(negedge clk);
      flush     = 1'b1;
      put_valid = 1'b1;
      put_data  = 32'hC3;
      get_ready = 1'b1;
      @(posedge clk);
      model_q.delete();
      #1;
      check_all("flush");
      @(negedge clk);
      flush = 1'b0;
      step(0, 32'h0, 0, "post_flush");
`endif

      // Randomized traffic with occasional reset.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(1);
         end else begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), "rand");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
